reg_dump_tx: RTL and testbench
==============================

# reg_dump_tx

Debug state transmitter for the RV32I core. On request it halts the core and streams the current PC and all 32 architectural registers as a byte-serial frame over a valid/ready interface. A bench, UART bridge or logic analyser on the far side receives the frame, so register state is exported by hardware rather than read through hierarchical peeks. It sits beside the register file and uses that file's spare combinational read port.

## Interface
- `HDR_BYTE`, default 8'hA5: frame start byte.
- `top_clk` input, 1: clock; all state updates on the rising edge.
- `top_rst` input, 1: asynchronous, active-high reset.
- `dump_req` input, 1: start request, sampled in IDLE only.
- `pc_in` input, 32: current PC, captured when the request is accepted.
- `rf_raddr` output, 5: register-file read address.
- `rf_rdata` input, 32: combinational read data for `rf_raddr`.
- `cpu_halt` output, 1: high while a frame is in progress; the core must freeze PC and register writes.
- `tx_data` output, 8: stream byte.
- `tx_valid` output, 1: `tx_data` is valid.
- `tx_ready` input, 1: sink accepts the byte; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `busy` output, 1: frame in progress.
- `done` output, 1: one-cycle pulse after the final transfer.

## Operation
- States: IDLE, HDR, WORD, CSUM (only with the macro), FIN.
- **IDLE:** `dump_req`=1 at an edge does three things: latch `pc_in` into a 32-bit word buffer, clear byte index and register index, go to HDR.
- **HDR:** `tx_data`=`HDR_BYTE`. On transfer, go to WORD with byte index 0.
- **WORD:**
  - `tx_data` = word buffer byte selected by the byte index, MSB first (byte 0 = [31:24]).
  - Each transfer increments the byte index.
  - On transfer of byte 3, the buffer loads `rf_rdata` for the next register and the register index increments.
  - Word order: PC, then x0..x31.
  - After x31 byte 3 is transferred, go to CSUM if compiled in, otherwise FIN.
- `rf_raddr` = register index at all times. x0 is sent exactly as the register file returns it.
- Frame length: 1 + 4 + 128 = 133 bytes, or 134 with the checksum.
- **FIN:** `done`=1 for one cycle, `busy` and `cpu_halt` drop, return to IDLE.
- `busy` = `cpu_halt` = (state != IDLE).
- `dump_req` outside IDLE is ignored and not queued. `dump_req` held high re-triggers only after FIN.
- `tx_valid` is high in HDR, WORD and CSUM only.
- Reset values of all outputs: `tx_valid`=0, `tx_data`=0, `busy`=0, `cpu_halt`=0, `done`=0, `rf_raddr`=0. State IDLE; counters and buffer 0.

## Timing
- `dump_req` sampled at edge 0 → `tx_valid`=1 with the header byte from edge 0 onward.
- With `tx_ready` tied high: one byte per cycle. The last byte transfers at edge 133 (134 with checksum). `done` is high in the following cycle.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data` and the internal state hold stable. There is no combinational path from `tx_ready` to `tx_valid`.
- `tx_ready` high with `tx_valid` low has no effect.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous) and the frame is abandoned. The next request starts a fresh frame beginning with the header.

## Configuration
- `REG_DUMP_CSUM_EN` defined: a CSUM state follows x31. It sends one byte equal to the XOR of every PC and register byte (the header is excluded), then goes to FIN. The checksum accumulator clears on request acceptance.
- Not defined: no CSUM state and no accumulator logic; FIN follows x31 directly.

## Test plan
- **Reset:** assert `top_rst` with random inputs → all outputs 0, and `dump_req` while in reset is ignored.
- **Full frame, ready high:** x_i = 32'h1000_0000+i (x0=0), `pc_in`=32'h0000_0040 → stream is A5 00 00 00 40, then 00 00 00 00, 10 00 00 01, …, 10 00 00 1F. `done` appears in the cycle after the 133rd transfer and `cpu_halt` is high throughout.
- **Backpressure:** same data with `tx_ready` toggling every cycle → identical byte sequence, `tx_data` constant across stalls, 265 cycles from request to last transfer.
- **Request while busy:** pulse `dump_req` at byte 20 → no effect, exactly one frame. A request after `done` → a new frame starting with A5 and the new `pc_in`.
- **Reset mid-frame:** assert `top_rst` during byte 50 → outputs reset in the same cycle. The next request produces a complete 133-byte frame.
- **`REG_DUMP_CSUM_EN`:** data from the full-frame test → byte 134 = 8'h50, `done` in the cycle after it. With all registers 0 and `pc_in`=0 → checksum 8'h00.

Source files
------------

// File: rtl/reg_dump_tx_if.sv
// Byte stream from reg_dump_tx to whatever receives the debug frame.
// Handshake: a byte moves on a rising edge where tx_valid && tx_ready; while tx_valid is high and
// tx_ready low, tx_data holds; tx_valid never depends combinationally on tx_ready.
interface reg_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_tx.sv
// Debug dump transmitter: halts the core and streams HDR_BYTE, the PC and x0..x31 MSB-first.
// Define REG_DUMP_CSUM_EN to append one XOR checksum byte over the PC and register bytes.
module reg_dump_tx #(
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic          top_clk,
  input  logic          top_rst,
  input  logic          dump_req,
  input  logic [31:0]   pc_in,
  output logic [4:0]    rf_raddr,
  input  logic [31:0]   rf_rdata,
  output logic          cpu_halt,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state,
  reg_dump_tx_if.master tx
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WORD = 3'd2,
`ifdef REG_DUMP_CSUM_EN
    S_CSUM = 3'd3,
`endif
    S_FIN  = 3'd4
  } state_t;

  // reg_idx counts words already loaded after the PC; while x31 is on the wire it reads 32.
  localparam logic [5:0] LAST_WORD = 6'd32;

  state_t      state, state_d;
  logic [1:0]  byte_idx, byte_idx_d;
  logic [5:0]  reg_idx, reg_idx_d;
  logic [31:0] word_buf, word_buf_d;
  logic [7:0]  cur_byte;
  logic [7:0]  tx_data_c;
  logic        tx_valid_c;
  logic        done_c;
`ifdef REG_DUMP_CSUM_EN
  logic [7:0]  csum, csum_d;
`endif

  always_comb begin
    cur_byte = word_buf[31:24];
    case (byte_idx)
      2'd0: cur_byte = word_buf[31:24];
      2'd1: cur_byte = word_buf[23:16];
      2'd2: cur_byte = word_buf[15:8];
      2'd3: cur_byte = word_buf[7:0];
      default: cur_byte = word_buf[31:24];
    endcase
  end

  always_comb begin
    state_d    = state;
    byte_idx_d = byte_idx;
    reg_idx_d  = reg_idx;
    word_buf_d = word_buf;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    done_c     = 1'b0;
`ifdef REG_DUMP_CSUM_EN
    csum_d     = csum;
`endif
    case (state)
      S_IDLE: begin
        if (dump_req) begin
          state_d    = S_HDR;
          word_buf_d = pc_in;
          byte_idx_d = 2'd0;
          reg_idx_d  = 6'd0;
`ifdef REG_DUMP_CSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      S_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = HDR_BYTE;
        if (tx.tx_ready) begin
          state_d    = S_WORD;
          byte_idx_d = 2'd0;
        end
      end
      S_WORD: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cur_byte;
        if (tx.tx_ready) begin
          byte_idx_d = byte_idx + 2'd1;
`ifdef REG_DUMP_CSUM_EN
          csum_d     = csum ^ cur_byte;
`endif
          if (byte_idx == 2'd3) begin
            // rf_raddr already points at the next register, so its data is ready to load.
            word_buf_d = rf_rdata;
            reg_idx_d  = reg_idx + 6'd1;
            if (reg_idx == LAST_WORD) begin
`ifdef REG_DUMP_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_FIN;
`endif
            end
          end
        end
      end
`ifdef REG_DUMP_CSUM_EN
      S_CSUM: begin
        tx_valid_c = 1'b1;
        tx_data_c  = csum;
        if (tx.tx_ready) begin
          state_d = S_FIN;
        end
      end
`endif
      S_FIN: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge top_clk or posedge top_rst) begin
    if (top_rst) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      reg_idx  <= 6'd0;
      word_buf <= 32'd0;
    end else begin
      state    <= state_d;
      byte_idx <= byte_idx_d;
      reg_idx  <= reg_idx_d;
      word_buf <= word_buf_d;
    end
  end

`ifdef REG_DUMP_CSUM_EN
  always_ff @(posedge top_clk or posedge top_rst) begin
    if (top_rst) begin
      csum <= 8'h00;
    end else begin
      csum <= csum_d;
    end
  end
`endif

  // Every output decodes from registered state, so reset clears them without waiting for a clock.
  assign tx.tx_valid = tx_valid_c;
  assign tx.tx_data  = tx_data_c;
  assign busy        = (state != S_IDLE);
  assign cpu_halt    = (state != S_IDLE);
  assign done        = done_c;
  assign rf_raddr    = reg_idx[4:0];
  assign dbg_state   = state;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: directed and randomized frames checked against a frame model built
// from the register-file contents and PC.
module tb_reg_dump_tx;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef REG_DUMP_CSUM_EN
  localparam int FRAME_LEN = 134;
`else
  localparam int FRAME_LEN = 133;
`endif

  logic        top_clk;
  logic        top_rst;
  logic        dump_req;
  logic [31:0] pc_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  reg_dump_tx_if dif ();

  logic [31:0] rf_mem [32];
  assign rf_rdata = rf_mem[rf_raddr];

  int tests_run;
  int tests_failed;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  reg_dump_tx #(.HDR_BYTE(8'hA5)) dut (
    .top_clk   (top_clk),
    .top_rst   (top_rst),
    .dump_req  (dump_req),
    .pc_in     (pc_in),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .tx        (dif)
  );

  // clock / reset
  initial begin
    top_clk = 1'b0;
    forever #5 top_clk = ~top_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, PC, x0..x31 big-endian, optional XOR of all data bytes.
  function automatic void build_frame(input logic [31:0] pc);
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  cs;
    exp_q.delete();
    exp_q.push_back(HDR);
    cs = 8'h00;
    for (int w = 0; w < 33; w++) begin
      v = (w == 0) ? pc : rf_mem[w-1];
      for (int i = 0; i < 4; i++) begin
        b = 8'(v >> (24 - 8 * i));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef REG_DUMP_CSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  // mode 0: ready high, 1: ready only on odd edges, 2: random
  function automatic logic ready_for(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 1;
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: starts at posedge+1, ends at posedge+1 with the DUT idle
  task automatic run_frame(input string name, input logic [31:0] pc, input int mode,
                           input int poke_at, input int abort_at, output int last_edge);
    int k;
    int halt_bad;
    int stall_bad;
    int nbad;
    logic stalled;
    logic poked;
    logic [7:0] held;
    build_frame(pc);
    got_q.delete();
    halt_bad = 0; stall_bad = 0; stalled = 1'b0; poked = 1'b0; held = 8'h00; last_edge = -1;
    dump_req = 1'b1;
    pc_in = pc;
    @(posedge top_clk); #1;
    dump_req = 1'b0;
    pc_in = $urandom;
    dif.tx_ready = ready_for(mode, 1);
    @(negedge top_clk);
    chk({name, "_hdr_valid"}, 32'(dif.tx_valid), 32'd1);
    chk({name, "_hdr_byte"}, 32'(dif.tx_data), 32'(HDR));
    k = 1;
    while (got_q.size() < exp_q.size() && k < 1000) begin
      if (!(cpu_halt && busy && !done && dif.tx_valid)) halt_bad++;
      if (stalled && dif.tx_data !== held) stall_bad++;
      if (dif.tx_valid && dif.tx_ready) begin
        got_q.push_back(dif.tx_data);
        last_edge = k;
        stalled = 1'b0;
      end else begin
        stalled = dif.tx_valid;
        held = dif.tx_data;
      end
      @(posedge top_clk); #1;
      k++;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        top_rst = 1'b1;
        #1;
        chk({name, "_rst_valid"}, 32'(dif.tx_valid), 32'd0);
        chk({name, "_rst_data"}, 32'(dif.tx_data), 32'd0);
        chk({name, "_rst_busy"}, 32'(busy), 32'd0);
        chk({name, "_rst_halt"}, 32'(cpu_halt), 32'd0);
        chk({name, "_rst_done"}, 32'(done), 32'd0);
        chk({name, "_rst_raddr"}, 32'(rf_raddr), 32'd0);
        #2 top_rst = 1'b0;
        @(posedge top_clk); #1;
        return;
      end
      if (!poked && poke_at >= 0 && got_q.size() == poke_at) begin
        dump_req = 1'b1;
        poked = 1'b1;
      end else begin
        dump_req = 1'b0;
      end
      dif.tx_ready = ready_for(mode, k);
    end
    dump_req = 1'b0;
    @(negedge top_clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd1);
    chk({name, "_valid_after"}, 32'(dif.tx_valid), 32'd0);
    @(negedge top_clk);
    chk({name, "_done_low"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"}, 32'({busy, cpu_halt}), 32'd0);
    chk({name, "_halt_held"}, 32'(halt_bad), 32'd0);
    chk({name, "_stall_stable"}, 32'(stall_bad), 32'd0);
    chk({name, "_length"}, 32'(got_q.size()), 32'(exp_q.size()));
    nbad = 0;
    foreach (exp_q[i]) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) nbad++;
    end
    chk({name, "_bytes"}, 32'(nbad), 32'd0);
    @(posedge top_clk); #1;
  endtask

  initial begin
    int le;
    int bad;
    tests_run = 0;
    tests_failed = 0;

    // reset with random inputs and a request that must be ignored
    top_rst = 1'b1;
    dump_req = 1'b1;
    pc_in = $urandom;
    dif.tx_ready = 1'($urandom_range(0, 1));
    foreach (rf_mem[i]) rf_mem[i] = $urandom;
    repeat (3) @(posedge top_clk);
    @(negedge top_clk);
    chk("reset_valid", 32'(dif.tx_valid), 32'd0);
    chk("reset_data", 32'(dif.tx_data), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_halt", 32'(cpu_halt), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_raddr", 32'(rf_raddr), 32'd0);
    @(posedge top_clk); #1;
    dump_req = 1'b0;
    top_rst = 1'b0;
    dif.tx_ready = 1'b1;
    repeat (3) @(negedge top_clk);
    chk("post_reset_idle", 32'({busy, dif.tx_valid}), 32'd0);
    @(posedge top_clk); #1;

    // full frame, ready high
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
    rf_mem[0] = 32'h0;
    run_frame("full", 32'h0000_0040, 0, -1, -1, le);
    chk("full_last_edge", 32'(le), 32'(FRAME_LEN));
    chk("full_pc_word", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0000_0040);
    chk("full_x1_word", {got_q[9], got_q[10], got_q[11], got_q[12]}, 32'h1000_0001);
    chk("full_x31_word", {got_q[129], got_q[130], got_q[131], got_q[132]}, 32'h1000_001F);
`ifdef REG_DUMP_CSUM_EN
    chk("full_csum", 32'(got_q[133]), 32'h50);
`endif

    // backpressure, ready toggling
    run_frame("bp", 32'h0000_0040, 1, -1, -1, le);
    chk("bp_last_edge", 32'(le), 32'(2 * FRAME_LEN - 1));

    // request while busy is dropped
    run_frame("busy_req", 32'h0000_0040, 0, 20, -1, le);
    bad = 0;
    repeat (4) begin
      @(negedge top_clk);
      if (busy || dif.tx_valid) bad++;
      @(posedge top_clk); #1;
    end
    chk("busy_req_no_second", 32'(bad), 32'd0);
    run_frame("after_done", 32'h0000_1234, 2, -1, -1, le);
    chk("after_done_pc", {got_q[1], got_q[2], got_q[3], got_q[4]}, 32'h0000_1234);

    // reset mid-frame, then a clean frame
    run_frame("abort", 32'h0000_0040, 0, -1, 50, le);
    run_frame("post_abort", 32'hCAFE_0000, 0, -1, -1, le);
    chk("post_abort_last_edge", 32'(le), 32'(FRAME_LEN));

    // random contents with random backpressure
    for (int r = 0; r < 3; r++) begin
      foreach (rf_mem[i]) rf_mem[i] = $urandom;
      run_frame($sformatf("rand%0d", r), $urandom, 2, -1, -1, le);
    end

    // all-zero state
    foreach (rf_mem[i]) rf_mem[i] = 32'h0;
    run_frame("zero", 32'h0, 0, -1, -1, le);
    chk("zero_last_byte", 32'(got_q[FRAME_LEN-1]), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
